// File: rtl/equiv_pkg.sv
// Shared types and helpers for the equivalence mismatch monitor.
// Holds the FSM encoding and the saturating counter increment.
package equiv_pkg;

   localparam int WIDTH_DEF = 91;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_WARMUP  = 2'd0,
      ST_COMPARE = 2'd1,
      ST_FAILED  = 2'd2,
      ST_DONE    = 2'd3
   } mon_state_t;

   // Increment that sticks at max_val instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
      logic [31:0] res;
      if (val >= max_val) begin
         res = val;
      end else begin
         res = val + 32'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/equiv_skew_line.sv
// Delay line that lines up the faster implementation's result with the slower one.
// Reports when it has been refilled with real data since reset or flush.
module equiv_skew_line
   import equiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full
);

   logic [3:0] fill_r;

   // Fill count: number of clocks the line has been loading since reset/flush, capped at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_r <= 4'd0;
      end else if (flush) begin
         fill_r <= 4'd0;
      end else if (fill_r != 4'(DEPTH)) begin
         fill_r <= fill_r + 4'd1;
      end
   end

   assign full = (fill_r == 4'(DEPTH));

   if (DEPTH == 0) begin : g_wire
      assign dout = din;
   end else begin : g_line
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift stages every clock regardless of data validity.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_r[i] <= '0;
         end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) stage_r[i] <= '0;
         end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
         end
      end

      assign dout = stage_r[DEPTH-1];
   end

endmodule

// File: rtl/equiv_mismatch_monitor.sv
// Compares the two equivalence-harness results after skew alignment and warm-up,
// counting mismatches and capturing the first failing pair with its compare index.
module equiv_mismatch_monitor
   import equiv_pkg::*;
#(
   parameter int WIDTH        = WIDTH_DEF,
   parameter int SKEW         = 0,
   parameter int WARMUP       = 4,
   parameter int RUN_CYCLES   = 0,
   parameter int STOP_ON_FAIL = 1,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] y_1,
   input  logic [WIDTH-1:0] y_2,
   output logic             mismatch,
   output logic             fail,
   output logic             done,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] first_cyc,
   output logic [WIDTH-1:0] first_y1,
   output logic [WIDTH-1:0] first_y2,
   output logic [WIDTH-1:0] first_diff
);

   localparam longint     CNT_MAX_L = (64'sd1 <<< CNT_W) - 64'sd1;
   localparam logic [31:0] CNT_MAX  = CNT_MAX_L[31:0];
   localparam mon_state_t INIT_ST   = (WARMUP == 32'sd0) ? ST_COMPARE : ST_WARMUP;
   localparam bit         STOP      = (STOP_ON_FAIL != 32'sd0);

   if (CNT_W < 32'sd1 || CNT_W > 32'sd32) begin : g_err_cnt_w
      $error("CNT_W must be within 1..32");
   end
   if (SKEW < 32'sd0 || SKEW > 32'sd7) begin : g_err_skew
      $error("SKEW must be within 0..7");
   end
   // A saturated compare index could never reach RUN_CYCLES, so done would never fire.
   if (longint'(RUN_CYCLES) > CNT_MAX_L || RUN_CYCLES < 32'sd0) begin : g_err_run
      $error("RUN_CYCLES exceeds the compare index range of CNT_W");
   end
   if (longint'(WARMUP) > CNT_MAX_L || WARMUP < 32'sd0) begin : g_err_warm
      $error("WARMUP exceeds the counter range of CNT_W");
   end

   mon_state_t       state_r, state_nxt_s;
   logic [WIDTH-1:0] y1_al_s;
   logic             full_s;
   logic             warm_smp_s, warm_last_s;
   logic             cmp_s, mis_s, last_s, capture_s;
   logic [CNT_W-1:0] warm_cnt_r, cmp_idx_r;
   logic             mismatch_r, fail_r, done_r;
   logic [CNT_W-1:0] mismatch_cnt_r, first_cyc_r;
   logic [WIDTH-1:0] first_y1_r, first_y2_r, first_diff_r;

   equiv_skew_line #(.WIDTH(WIDTH), .DEPTH(SKEW)) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (clear),
      .din   (y_1),
      .dout  (y1_al_s),
      .full  (full_s)
   );

   assign warm_last_s = ((32'(warm_cnt_r) + 32'd1) == 32'(WARMUP));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= INIT_ST;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; clear overrides any sample in the same cycle.
   always_comb begin
      state_nxt_s = state_r;
      if (clear) begin
         state_nxt_s = INIT_ST;
      end else begin
         case (state_r)
            ST_WARMUP: begin
               if (warm_smp_s && warm_last_s) state_nxt_s = ST_COMPARE;
               else                           state_nxt_s = state_r;
            end
            ST_COMPARE: begin
               if (mis_s && STOP) state_nxt_s = ST_FAILED;
               else if (last_s)   state_nxt_s = ST_DONE;
               else               state_nxt_s = state_r;
            end
            ST_FAILED: state_nxt_s = state_r;
            ST_DONE:   state_nxt_s = state_r;
            default:   state_nxt_s = INIT_ST;
         endcase
      end
   end

   // Per-sample decode: warm-up count, compare, and first-failure capture enables.
   always_comb begin
      warm_smp_s = 1'b0;
      cmp_s      = 1'b0;
      mis_s      = 1'b0;
      last_s     = 1'b0;
      capture_s  = 1'b0;
      if (en && full_s && !clear) begin
         warm_smp_s = (state_r == ST_WARMUP);
         cmp_s      = (state_r == ST_COMPARE);
         mis_s      = cmp_s && (y1_al_s != y_2);
         last_s     = cmp_s && (RUN_CYCLES != 32'sd0) &&
                      ((32'(cmp_idx_r) + 32'd1) == 32'(RUN_CYCLES));
         capture_s  = mis_s && !fail_r;
      end else begin
         cmp_s = 1'b0;
      end
   end

   // Counters, sticky flags and capture registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm_cnt_r     <= '0;
         cmp_idx_r      <= '0;
         mismatch_r     <= 1'b0;
         fail_r         <= 1'b0;
         done_r         <= 1'b0;
         mismatch_cnt_r <= '0;
         first_cyc_r    <= '0;
         first_y1_r     <= '0;
         first_y2_r     <= '0;
         first_diff_r   <= '0;
      end else if (clear) begin
         warm_cnt_r     <= '0;
         cmp_idx_r      <= '0;
         mismatch_r     <= 1'b0;
         fail_r         <= 1'b0;
         done_r         <= 1'b0;
         mismatch_cnt_r <= '0;
         first_cyc_r    <= '0;
         first_y1_r     <= '0;
         first_y2_r     <= '0;
         first_diff_r   <= '0;
      end else begin
         mismatch_r <= mis_s;
         if (warm_smp_s) warm_cnt_r <= CNT_W'(sat_inc(32'(warm_cnt_r), CNT_MAX));
         if (cmp_s)      cmp_idx_r  <= CNT_W'(sat_inc(32'(cmp_idx_r), CNT_MAX));
         if (mis_s) begin
            mismatch_cnt_r <= CNT_W'(sat_inc(32'(mismatch_cnt_r), CNT_MAX));
            fail_r         <= 1'b1;
         end
         if (capture_s) begin
            first_cyc_r  <= cmp_idx_r;
            first_y1_r   <= y1_al_s;
            first_y2_r   <= y_2;
            first_diff_r <= y1_al_s ^ y_2;
         end
         if (last_s && !(mis_s && STOP)) done_r <= 1'b1;
      end
   end

   assign mismatch     = mismatch_r;
   assign fail         = fail_r;
   assign done         = done_r;
   assign mismatch_cnt = mismatch_cnt_r;
   assign first_cyc    = first_cyc_r;
   assign first_y1     = first_y1_r;
   assign first_y2     = first_y2_r;
   assign first_diff   = first_diff_r;

endmodule

// File: tb/tb_equiv_mismatch_monitor.sv
// Directed bench for equiv_mismatch_monitor: five parameter variants share one stimulus bus,
// and the instance under test for each step is chosen by sel.
module tb_equiv_mismatch_monitor;
   import equiv_pkg::*;

   localparam int N = 5;

   logic          clk = 1'b0;
   logic          rst_n, clear, en;
   logic [90:0]   y_1, y_2;
   logic [N-1:0]  mis_o, fail_o, done_o;
   logic [N-1:0][15:0] cnt_o, fcyc_o;
   logic [N-1:0][90:0] fy1_o, fy2_o, fdiff_o;

   int checks = 0;
   int errors = 0;
   int sel    = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   // 0: default, 1: no stop-on-fail, 2: skew 2, 3: skew 1, 4: run 10 compares
   for (genvar g = 0; g < N; g++) begin : gen_dut
      equiv_mismatch_monitor #(
         .WIDTH        (91),
         .SKEW         (g == 2 ? 2 : (g == 3 ? 1 : 0)),
         .WARMUP       (4),
         .RUN_CYCLES   (g == 4 ? 10 : 0),
         .STOP_ON_FAIL (g == 1 ? 0 : 1),
         .CNT_W        (16)
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .clear        (clear),
         .en           (en),
         .y_1          (y_1),
         .y_2          (y_2),
         .mismatch     (mis_o[g]),
         .fail         (fail_o[g]),
         .done         (done_o[g]),
         .mismatch_cnt (cnt_o[g]),
         .first_cyc    (fcyc_o[g]),
         .first_y1     (fy1_o[g]),
         .first_y2     (fy2_o[g]),
         .first_diff   (fdiff_o[g])
      );
   end

   task automatic check(input string tag, input logic [90:0] obs, input logic [90:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [90:0] rnd91();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[90:0];
   endfunction

   // Drive one cycle, queue the expected pulse, then compare it one edge later.
   task automatic step(input bit c, input bit e, input logic [90:0] a, input logic [90:0] b,
                       input bit exp_mis);
      bit exp_v;
      clear = c; en = e; y_1 = a; y_2 = b;
      exp_q.push_back(exp_mis);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      check("mismatch_pulse", {90'd0, mis_o[sel]}, {90'd0, exp_v});
   endtask

   task automatic do_reset();
      rst_n = 1'b0; clear = 1'b0; en = 1'b0; y_1 = '0; y_2 = '0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic [90:0] r, mask, cap_a, cap_b, p1, p2;
      logic [90:0] one_v;
      int smp;
      bit m, e;
      one_v = 91'h1;

      // Reset values
      rst_n = 1'b0; clear = 1'b0; en = 1'b0; y_1 = '0; y_2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mismatch", {90'd0, mis_o[0]}, 91'd0);
      check("rst_fail", {90'd0, fail_o[0]}, 91'd0);
      check("rst_done", {90'd0, done_o[0]}, 91'd0);
      check("rst_cnt", {75'd0, cnt_o[0]}, 91'd0);
      check("rst_first_cyc", {75'd0, fcyc_o[0]}, 91'd0);
      check("rst_first_y1", fy1_o[0], 91'd0);
      check("rst_first_y2", fy2_o[0], 91'd0);
      check("rst_first_diff", fdiff_o[0], 91'd0);
      check("rst_state", 91'(gen_dut[0].u_dut.state_r), 91'(ST_WARMUP));
      rst_n = 1'b1;

      // Equal random streams never mismatch
      sel = 0;
      for (int i = 0; i < 100; i++) begin
         r = rnd91();
         step(1'b0, 1'b1, r, r, 1'b0);
      end
      check("eq_cnt", {75'd0, cnt_o[0]}, 91'd0);
      check("eq_fail", {90'd0, fail_o[0]}, 91'd0);

      // Warm-up differences ignored, stall ignored, first compare mismatch at index 2
      do_reset();
      for (int i = 0; i < 4; i++) begin
         r = rnd91();
         step(1'b0, 1'b1, r, r ^ one_v, 1'b0);
      end
      check("warm_fail", {90'd0, fail_o[0]}, 91'd0);
      r = rnd91();
      step(1'b0, 1'b1, r, r, 1'b0);
      step(1'b0, 1'b0, r, r ^ one_v, 1'b0);
      step(1'b0, 1'b1, r, r, 1'b0);
      cap_a = rnd91();
      step(1'b0, 1'b1, cap_a, cap_a ^ one_v, 1'b1);
      check("f2_fail", {90'd0, fail_o[0]}, 91'd1);
      check("f2_cnt", {75'd0, cnt_o[0]}, 91'd1);
      check("f2_first_cyc", {75'd0, fcyc_o[0]}, 91'd2);
      check("f2_first_diff", fdiff_o[0], one_v);
      check("f2_first_y1", fy1_o[0], cap_a);
      check("f2_first_y2", fy2_o[0], cap_a ^ one_v);
      check("f2_state", 91'(gen_dut[0].u_dut.state_r), 91'(ST_FAILED));
      for (int i = 0; i < 2; i++) begin
         r = rnd91();
         step(1'b0, 1'b1, r, ~r, 1'b0);
      end
      check("f2_cnt_frozen", {75'd0, cnt_o[0]}, 91'd1);

      // Keep comparing after failures; mismatches at compares 5, 9, 12
      sel = 1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         r = rnd91();
         step(1'b0, 1'b1, r, r, 1'b0);
      end
      mask = rnd91() | one_v;
      cap_a = '0; cap_b = '0;
      for (int k = 0; k < 15; k++) begin
         r = rnd91();
         m = (k == 5 || k == 9 || k == 12);
         if (k == 5) begin
            cap_a = r;
            cap_b = r ^ mask;
         end
         step(1'b0, 1'b1, r, m ? (r ^ mask) : r, m);
      end
      check("f3_cnt", {75'd0, cnt_o[1]}, 91'd3);
      check("f3_first_cyc", {75'd0, fcyc_o[1]}, 91'd5);
      check("f3_first_y1", fy1_o[1], cap_a);
      check("f3_first_y2", fy2_o[1], cap_b);
      check("f3_first_diff", fdiff_o[1], mask);
      check("f3_state", 91'(gen_dut[1].u_dut.state_r), 91'(ST_COMPARE));

      // y_2 lags y_1 by two cycles: SKEW=2 aligns, SKEW=1 does not
      sel = 2;
      do_reset();
      p1 = '0; p2 = '0;
      for (int k = 0; k < 30; k++) begin
         r = rnd91();
         step(1'b0, 1'b1, r, p2, 1'b0);
         p2 = p1;
         p1 = r;
      end
      check("skew2_fail", {90'd0, fail_o[2]}, 91'd0);
      check("skew2_cnt", {75'd0, cnt_o[2]}, 91'd0);
      check("skew1_fail", {90'd1 & 90'd0, fail_o[3]}, 91'd1);

      // RUN_CYCLES=10 with en toggling: done after the 10th compare, then frozen
      sel = 4;
      do_reset();
      smp = 0;
      for (int k = 0; k < 28; k++) begin
         e = ((k % 2) == 0);
         r = rnd91();
         step(1'b0, e, r, r, 1'b0);
         if (e) smp++;
         check("run_done", {90'd0, done_o[4]}, {90'd0, (smp >= 14)});
      end
      for (int k = 0; k < 4; k++) begin
         r = rnd91();
         step(1'b0, 1'b1, r, ~r, 1'b0);
      end
      check("run_cnt", {75'd0, cnt_o[4]}, 91'd0);
      check("run_fail", {90'd0, fail_o[4]}, 91'd0);
      check("run_state", 91'(gen_dut[4].u_dut.state_r), 91'(ST_DONE));

      // Asynchronous reset mid-compare, then clear beating en in the same cycle
      sel = 1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         r = rnd91();
         step(1'b0, 1'b1, r, r, 1'b0);
      end
      r = rnd91();
      step(1'b0, 1'b1, r, r ^ one_v, 1'b1);
      check("pre_rst_fail", {90'd0, fail_o[1]}, 91'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_mismatch", {90'd0, mis_o[1]}, 91'd0);
      check("arst_fail", {90'd0, fail_o[1]}, 91'd0);
      check("arst_cnt", {75'd0, cnt_o[1]}, 91'd0);
      check("arst_first_diff", fdiff_o[1], 91'd0);
      check("arst_first_y1", fy1_o[1], 91'd0);
      check("arst_state", 91'(gen_dut[1].u_dut.state_r), 91'(ST_WARMUP));
      do_reset();
      for (int i = 0; i < 4; i++) begin
         r = rnd91();
         step(1'b0, 1'b1, r, r, 1'b0);
      end
      r = rnd91();
      step(1'b0, 1'b1, r, r, 1'b0);
      step(1'b0, 1'b1, r, r ^ one_v, 1'b1);
      step(1'b1, 1'b1, r, r ^ one_v, 1'b0);
      check("clr_state", 91'(gen_dut[1].u_dut.state_r), 91'(ST_WARMUP));
      check("clr_fail", {90'd0, fail_o[1]}, 91'd0);
      check("clr_cnt", {75'd0, cnt_o[1]}, 91'd0);
      check("clr_first_diff", fdiff_o[1], 91'd0);
      step(1'b0, 1'b1, r, r ^ one_v, 1'b0);
      check("clr_warm_fail", {90'd0, fail_o[1]}, 91'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
